udma_l2_arbiter: RTL

UDMA_L2_ARBITER -- requirements
Module: udma_l2_arbiter

---
 rtl/udma_l2_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/udma_l2_arbiter.sv
// -----------------------------------------------------------------------------
// udma_l2_arbiter
//
// Round-robin arbiter that funnels N_CH uDMA channel write requests into a
// single registered L2 request port. The output stage is one register
// (EMPTY/FULL). When the stage is EMPTY, or FULL and accepted by L2 in this
// cycle, a new channel is selected, granted combinationally and its payload
// is captured. Sustained throughput is one transfer per cycle.
//
// Optional feature: define UDMA_L2_ARB_PRIO_EN to add ch_prio_i. When any
// requesting channel has its prio bit set, only prio requesters are eligible.
// Both classes share one round-robin pointer.
//
// Parameters
//   N_CH      number of channels (2..16)
//   AWIDTH    word address width
//   DWIDTH    data width
//   ID_WIDTH  channel index width
//
// Ports
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   ch_req_i       per-channel request (level, held until granted)
//   ch_addr_i      per-channel address, channel c at [c*AWIDTH +: AWIDTH]
//   ch_data_i      per-channel data,    channel c at [c*DWIDTH +: DWIDTH]
//   ch_datasize_i  per-channel size,    channel c at [c*2 +: 2]
//   ch_prio_i      per-channel priority (only with UDMA_L2_ARB_PRIO_EN)
//   ch_gnt_o       one-hot single-cycle grant
//   l2_req_o       output stage holds a transfer
//   l2_gnt_i       L2 accepts the held transfer
//   l2_addr_o / l2_data_o / l2_datasize_o / l2_id_o  registered payload
// -----------------------------------------------------------------------------
module udma_l2_arbiter #(
  parameter int N_CH     = 4,
  parameter int AWIDTH   = 19,
  parameter int DWIDTH   = 32,
  parameter int ID_WIDTH = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_CH-1:0]        ch_req_i,
  input  logic [N_CH*AWIDTH-1:0] ch_addr_i,
  input  logic [N_CH*DWIDTH-1:0] ch_data_i,
  input  logic [N_CH*2-1:0]      ch_datasize_i,
`ifdef UDMA_L2_ARB_PRIO_EN
  input  logic [N_CH-1:0]        ch_prio_i,
`endif
  output logic [N_CH-1:0]        ch_gnt_o,
  output logic                   l2_req_o,
  input  logic                   l2_gnt_i,
  output logic [AWIDTH-1:0]      l2_addr_o,
  output logic [DWIDTH-1:0]      l2_data_o,
  output logic [1:0]             l2_datasize_o,
  output logic [ID_WIDTH-1:0]    l2_id_o
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [1:0]          size_q, size_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  logic [N_CH-1:0]     elig;
  logic [ID_WIDTH-1:0] sel_idx;
  logic                arb_en;
  logic                do_gnt;
  logic [N_CH-1:0]     gnt;

  // Eligible set: prio requesters mask out the rest when any are present.
`ifdef UDMA_L2_ARB_PRIO_EN
  logic [N_CH-1:0] prio_req;
  assign prio_req = ch_req_i & ch_prio_i;
  assign elig     = (|prio_req) ? prio_req : ch_req_i;
`else
  assign elig = ch_req_i;
`endif

  // Round-robin search from last_q+1 upward with wrap. The loop runs from the
  // farthest offset to the nearest, so the last hit (nearest to last_q+1)
  // wins without needing a found flag.
  always_comb begin
    sel_idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (elig[(int'(last_q) + k) % N_CH]) begin
        sel_idx = ID_WIDTH'((int'(last_q) + k) % N_CH);
      end
    end
  end

  // Arbitrate when empty, or when L2 drains the stage this cycle.
  assign arb_en = (state_q == ST_EMPTY) || l2_gnt_i;
  assign do_gnt = arb_en && (|elig);

  always_comb begin
    gnt = '0;
    if (do_gnt) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  // Grant is combinational; force it low while reset is asserted.
  assign ch_gnt_o = gnt & {N_CH{rstn_i}};

  // Next-state and payload capture.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    id_d    = id_q;
    if (do_gnt) begin
      state_d = ST_FULL;
      last_d  = sel_idx;
      addr_d  = ch_addr_i[int'(sel_idx)*AWIDTH +: AWIDTH];
      data_d  = ch_data_i[int'(sel_idx)*DWIDTH +: DWIDTH];
      size_d  = ch_datasize_i[int'(sel_idx)*2 +: 2];
      id_d    = sel_idx;
    end else if (arb_en) begin
      // Accepted (or already empty) with nothing to reload.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_EMPTY;
      last_q  <= ID_WIDTH'(N_CH - 1);
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      id_q    <= id_d;
    end
  end

  assign l2_req_o      = (state_q == ST_FULL);
  assign l2_addr_o     = addr_q;
  assign l2_data_o     = data_q;
  assign l2_datasize_o = size_q;
  assign l2_id_o       = id_q;

endmodule
